text_buf: RTL and testbench
===========================

# text_buf

Parametrised single-clock text-mode character buffer between the CPU-side character writer and the VGA text renderer. It stores one character per screen cell and offers a registered read port for the renderer and a write port for software. It adds hardware scroll through a circular top-row offset and a background clear engine for full-screen clear and scroll-line clear. It replaces the fixed 4096x8 dual-clock buffer.

## Interface
Parameters:
- COLS, 80, visible columns
- ROWS, 30, visible rows
- COL_BITS, 7, column index width; 2^COL_BITS >= COLS
- ROW_BITS, 5, row index width; 2^ROW_BITS >= ROWS
- DATA_W, 8, bits per cell
- FILL, 8'h20, value written by clear operations (space)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- we  in  1  CPU write strobe
- wr_row  in  ROW_BITS  logical row of the write
- wr_col  in  COL_BITS  column of the write
- wr_data  in  DATA_W  cell value
- rd_row  in  ROW_BITS  logical row requested by the renderer
- rd_col  in  COL_BITS  column requested by the renderer
- rd_data  out  DATA_W  registered cell value
- scroll_req  in  1  scroll up one line (single-cycle pulse)
- clear_req  in  1  clear whole screen (single-cycle pulse)
- busy  out  1  clear engine active
- top  out  ROW_BITS  current physical row shown as logical row 0

## Operation
- Storage: 2^(ROW_BITS+COL_BITS) cells; cell address = {phys_row, col}. Contents are not reset.
- Logical-to-physical row mapping: phys = row + top; if phys >= ROWS, subtract ROWS. All sums are ROW_BITS+1 wide.
- Write: when we=1, busy=0 and the coordinates are in range, the cell is written at the edge. Writes are dropped while busy=1 or when row >= ROWS or col >= COLS.
- Read: rd_data is the cell at (rd_row, rd_col) mapped with the top value current in the request cycle. An out-of-range coordinate returns FILL. A read of a cell written in the same cycle returns the old value (read-first).
- FSM states: IDLE, CLR_ALL, CLR_ROW.
  - IDLE + clear_req: set top to 0 and go to CLR_ALL. The counter starts at phys row 0, col 0.
  - IDLE + scroll_req (clear_req=0): set top to (top+1) mod ROWS, then go to CLR_ROW and clear the old top physical row, which is the new logical row ROWS-1.
  - clear_req and scroll_req in the same cycle: clear wins and scroll is dropped.
  - Requests that arrive while busy are ignored. Requests are not queued.
  - CLR_ALL writes FILL to one cell per cycle in col-major-inner order (col 0..COLS-1, then next row) up to (ROWS-1, COLS-1), then returns to IDLE.
  - CLR_ROW writes FILL to cols 0..COLS-1 of the target row, then returns to IDLE.
- During a clear, reads are serviced normally and may return either stale data or FILL, depending on progress.
- Reset mid-clear: return to IDLE and set top=0. Cells already cleared stay cleared and the rest are untouched.

## Timing
- Reset values: rd_data=0, busy=0, top=0, state IDLE.
- Read latency is 1 cycle: an address presented before edge N appears on rd_data after edge N.
- A request is accepted at edge N. top updates at edge N. Clear writes occur at edges N+1..N+K, with K=ROWS*COLS (2400 at defaults) for a full clear and K=COLS (80) for a scroll clear.
- busy is 1 exactly during cycles N+1..N+K, and a new request is accepted no earlier than edge N+K+1.
- A CPU write in the accept cycle (edge N) is performed, because the engine writes nothing at N.

## Structure
- Package text_buf_pkg holds the state enum (IDLE, CLR_ALL, CLR_ROW), the default geometry constants and the FILL default.
- Sub-module text_buf_ram: single-clock simple-dual-port RAM with 1 write port and 1 registered read-first read port, parametrised by address width and DATA_W. The top level muxes the write port between the CPU and the clear engine, holds the row-mapping adders, the top register and the FSM/counters.

## Test plan
- Reset, then issue clear_req -> busy high for 2400 cycles. After that, every (r,c) in range reads 8'h20 with 1-cycle latency.
- Write 'h' to (0,1) and 'A' to (29,0) after clear, then issue scroll_req -> top=1 and busy is high for 80 cycles. Afterwards (28,0) reads 'A', logical row 29 reads all 8'h20, and 'h' is no longer visible at row 0.
- Scroll 30 times (waiting for busy to clear each time) -> top wraps to 0 after the 30th. The mapping matches a software model at each step.
- Assert we during busy, and at col=80 or row=30 -> the target cells are unchanged. Out-of-range reads return 8'h20.
- Assert clear_req and scroll_req in the same cycle -> full clear (2400 busy cycles) and top=0. Write and read the same cell in the same cycle -> the old value is returned, then the new value on the next read.
- Start a full clear, drop rst_n at cycle 100 -> next cycle busy=0 and top=0. Cells before the reset point read 8'h20 and later cells keep their prior data.

Source files
------------

// File: rtl/text_buf_pkg.sv
// Shared types and default geometry for the text-mode character buffer.
package text_buf_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CLR_ALL,
      CLR_ROW
   } state_e;

   localparam int         DEF_COLS     = 80;
   localparam int         DEF_ROWS     = 30;
   localparam int         DEF_COL_BITS = 7;
   localparam int         DEF_ROW_BITS = 5;
   localparam int         DEF_DATA_W   = 8;
   localparam logic [7:0] DEF_FILL     = 8'h20;

endpackage

// File: rtl/text_buf_ram.sv
// Single-clock simple-dual-port RAM: one write port, one registered read-first read port.
module text_buf_ram #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: the array has no reset so it maps onto block RAM; a reset would force it into flops.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/text_buf.sv
// Text-mode character buffer with circular-row hardware scroll and a background clear engine.
module text_buf
   import text_buf_pkg::*;
#(
   parameter int                COLS     = DEF_COLS,
   parameter int                ROWS     = DEF_ROWS,
   parameter int                COL_BITS = DEF_COL_BITS,
   parameter int                ROW_BITS = DEF_ROW_BITS,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [DATA_W-1:0] FILL     = DATA_W'(DEF_FILL)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [ROW_BITS-1:0] wr_row,
   input  logic [COL_BITS-1:0] wr_col,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [ROW_BITS-1:0] rd_row,
   input  logic [COL_BITS-1:0] rd_col,
   output logic [DATA_W-1:0]   rd_data,
   input  logic                scroll_req,
   input  logic                clear_req,
   output logic                busy,
   output logic [ROW_BITS-1:0] top
);

   localparam int                 ADDR_W   = ROW_BITS + COL_BITS;
   localparam logic [ROW_BITS:0]   ROWS_W   = (ROW_BITS+1)'(ROWS);
   localparam logic [COL_BITS:0]   COLS_W   = (COL_BITS+1)'(COLS);
   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS-1);
   localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS-1);

   state_e              state_q, state_d;
   logic [ROW_BITS-1:0] top_q, top_d;
   logic [ROW_BITS-1:0] row_cnt_q, row_cnt_d;
   logic [COL_BITS-1:0] col_cnt_q, col_cnt_d;
   logic                rd_oob_q, rd_oob_d;
   logic                rd_vld_q, rd_vld_d;
   logic [ROW_BITS:0]   top_inc;
   logic                wr_ok;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_waddr, ram_raddr;
   logic [DATA_W-1:0]   ram_wdata, ram_rdata;

   // Logical row to physical row; both operands are below ROWS, so one subtraction suffices.
   function automatic logic [ROW_BITS-1:0] map_row(input logic [ROW_BITS-1:0] row,
                                                   input logic [ROW_BITS-1:0] base);
      logic [ROW_BITS:0] sum;
      sum = {1'b0, row} + {1'b0, base};
      if (sum >= ROWS_W) sum = sum - ROWS_W;
      return sum[ROW_BITS-1:0];
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         top_q     <= '0;
         row_cnt_q <= '0;
         col_cnt_q <= '0;
         rd_oob_q  <= 1'b0;
         rd_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         top_q     <= top_d;
         row_cnt_q <= row_cnt_d;
         col_cnt_q <= col_cnt_d;
         rd_oob_q  <= rd_oob_d;
         rd_vld_q  <= rd_vld_d;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      top_d     = top_q;
      row_cnt_d = row_cnt_q;
      col_cnt_d = col_cnt_q;
      top_inc   = {1'b0, top_q} + (ROW_BITS+1)'(1);
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               top_d     = '0;
               row_cnt_d = '0;
               col_cnt_d = '0;
               state_d   = CLR_ALL;
            end else if (scroll_req) begin
               // The old top row becomes the new bottom line and is the one cleared.
               top_d     = (top_inc >= ROWS_W) ? '0 : top_inc[ROW_BITS-1:0];
               row_cnt_d = top_q;
               col_cnt_d = '0;
               state_d   = CLR_ROW;
            end
         end
         CLR_ALL: begin
            if (col_cnt_q == COL_LAST) begin
               col_cnt_d = '0;
               if (row_cnt_q == ROW_LAST) state_d = IDLE;
               else row_cnt_d = row_cnt_q + ROW_BITS'(1);
            end else begin
               col_cnt_d = col_cnt_q + COL_BITS'(1);
            end
         end
         CLR_ROW: begin
            if (col_cnt_q == COL_LAST) begin
               col_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               col_cnt_d = col_cnt_q + COL_BITS'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q != IDLE);
      wr_ok = we && !busy && ({1'b0, wr_row} < ROWS_W) && ({1'b0, wr_col} < COLS_W);
      // Writes are held off on the reset edge so an interrupted clear stops cleanly.
      ram_we = rst_n && (busy || wr_ok);
      if (busy) begin
         ram_waddr = {row_cnt_q, col_cnt_q};
         ram_wdata = FILL;
      end else begin
         ram_waddr = {map_row(wr_row, top_q), wr_col};
         ram_wdata = wr_data;
      end
      ram_raddr = {map_row(rd_row, top_q), rd_col};
      rd_oob_d  = !(({1'b0, rd_row} < ROWS_W) && ({1'b0, rd_col} < COLS_W));
      rd_vld_d  = 1'b1;
   end

   text_buf_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign rd_data = !rd_vld_q ? '0 : (rd_oob_q ? FILL : ram_rdata);
   assign top     = top_q;

endmodule

// File: tb/tb_text_buf.sv
// Self-checking bench for text_buf against a logical-screen reference model.
module tb_text_buf;

   localparam int         ROWS = 30;
   localparam int         COLS = 80;
   localparam logic [7:0] FILL = 8'h20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       we;
   logic [4:0] wr_row;
   logic [6:0] wr_col;
   logic [7:0] wr_data;
   logic [4:0] rd_row;
   logic [6:0] rd_col;
   logic [7:0] rd_data;
   logic       scroll_req;
   logic       clear_req;
   logic       busy;
   logic [4:0] top;

   int checks = 0;
   int errors = 0;

   // Screen as seen by software: indexed by logical row, independent of the physical layout.
   logic [7:0] scr [ROWS][COLS];
   int         top_m;

   always #5 clk = ~clk;

   text_buf dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (we),
      .wr_row     (wr_row),
      .wr_col     (wr_col),
      .wr_data    (wr_data),
      .rd_row     (rd_row),
      .rd_col     (rd_col),
      .rd_data    (rd_data),
      .scroll_req (scroll_req),
      .clear_req  (clear_req),
      .busy       (busy),
      .top        (top)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) scr[r][c] = FILL;
      top_m = 0;
   endtask

   task automatic model_scroll();
      for (int r = 0; r < ROWS - 1; r++)
         for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = FILL;
      top_m = (top_m + 1) % ROWS;
   endtask

   task automatic rd_check(input int r, input int c, input string tag);
      logic [7:0] exp;
      rd_row = 5'(r);
      rd_col = 7'(c);
      tick();
      if (r < ROWS && c < COLS) exp = scr[r][c];
      else exp = FILL;
      check($sformatf("%s(%0d,%0d)", tag, r, c), 32'(rd_data), 32'(exp));
   endtask

   task automatic read_all(input string tag);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) rd_check(r, c, tag);
   endtask

   task automatic cpu_write(input int r, input int c, input logic [7:0] d);
      we      = 1'b1;
      wr_row  = 5'(r);
      wr_col  = 7'(c);
      wr_data = d;
      tick();
      we = 1'b0;
      if (r < ROWS && c < COLS) scr[r][c] = d;
   endtask

   task automatic rand_writes(input int n);
      for (int i = 0; i < n; i++)
         cpu_write($urandom_range(ROWS-1), $urandom_range(COLS-1), 8'($urandom));
   endtask

   task automatic pulse(input logic clr, input logic scl);
      clear_req  = clr;
      scroll_req = scl;
      tick();
      clear_req  = 1'b0;
      scroll_req = 1'b0;
   endtask

   task automatic wait_busy(input int k, input string tag);
      int n = 0;
      while (busy === 1'b1 && n < k + 8) begin
         n++;
         tick();
      end
      check(tag, 32'(n), 32'(k));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; we = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
      rd_row = '0; rd_col = '0; scroll_req = 1'b0; clear_req = 1'b0;
      top_m = 0;
      repeat (3) tick();
      check("rst_rd_data", 32'(rd_data), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_top", 32'(top), 32'h0);
      rst_n = 1'b1;
      tick();

      // Full clear from reset.
      pulse(1'b1, 1'b0);
      check("clr_top", 32'(top), 32'h0);
      wait_busy(ROWS*COLS, "clr_all_busy_len");
      model_clear();
      read_all("after_clear");

      // Markers, then one scroll.
      cpu_write(0, 1, "h");
      cpu_write(ROWS-1, 0, "A");
      rand_writes(20);
      pulse(1'b0, 1'b1);
      model_scroll();
      check("scroll1_top", 32'(top), 32'(top_m));
      wait_busy(COLS, "scroll1_busy_len");
      read_all("after_scroll1");

      // Writes and a clear request during busy are dropped.
      pulse(1'b0, 1'b1);
      model_scroll();
      for (int i = 0; i < 5; i++) begin
         we = 1'b1;
         wr_row = 5'($urandom_range(ROWS-1));
         wr_col = 7'($urandom_range(COLS-1));
         wr_data = 8'($urandom);
         tick();
      end
      we = 1'b0;
      pulse(1'b1, 1'b0);
      check("busy_req_ignored_top", 32'(top), 32'(top_m));
      wait_busy(COLS - 6, "scroll2_busy_len");
      cpu_write(ROWS, 5, 8'h99);
      cpu_write(3, COLS, 8'h98);
      cpu_write(31, 127, 8'h97);
      rd_check(ROWS, 0, "oob_rd");
      rd_check(0, COLS, "oob_rd");
      rd_check(31, 127, "oob_rd");
      read_all("after_drops");

      // Simultaneous clear and scroll: clear wins.
      pulse(1'b1, 1'b1);
      check("both_req_top", 32'(top), 32'h0);
      wait_busy(ROWS*COLS, "both_req_busy_len");
      model_clear();
      rand_writes(30);

      // Read-first on a same-cycle write.
      cpu_write(5, 5, 8'h41);
      we = 1'b1; wr_row = 5'd5; wr_col = 7'd5; wr_data = 8'h5a;
      rd_row = 5'd5; rd_col = 7'd5;
      tick();
      we = 1'b0;
      check("read_first_old", 32'(rd_data), 32'h41);
      scr[5][5] = 8'h5a;
      rd_check(5, 5, "read_first_new");

      // Thirty scrolls wrap top back to zero.
      for (int s = 0; s < ROWS; s++) begin
         rand_writes(3);
         pulse(1'b0, 1'b1);
         model_scroll();
         check($sformatf("scroll_top_%0d", s), 32'(top), 32'(top_m));
         wait_busy(COLS, "scroll_busy_len");
         for (int i = 0; i < 10; i++)
            rd_check($urandom_range(ROWS-1), $urandom_range(COLS-1), "scroll_rd");
         rd_check(ROWS-1, $urandom_range(COLS-1), "scroll_bottom");
      end
      check("scroll_wrap_top", 32'(top), 32'h0);
      read_all("after_wrap");

      // Reset interrupts a full clear after 100 cells.
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < COLS; c++) cpu_write(r, c, 8'($urandom_range(255, 128)));
      pulse(1'b1, 1'b0);
      repeat (100) tick();
      rst_n = 1'b0;
      tick();
      check("midclr_busy", 32'(busy), 32'h0);
      check("midclr_top", 32'(top), 32'h0);
      check("midclr_rd_data", 32'(rd_data), 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) scr[i / COLS][i % COLS] = FILL;
      top_m = 0;
      read_all("after_midclr");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
